mem_req_ctrl: RTL and testbench

//  Upstream request controller for the single-port handshake memory (valid/wr_rd/ready).

---
 rtl/mem_req_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_req_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// Request controller for a single-port valid/ready memory: queues host requests in a FIFO,
// issues them one at a time, returns read data on a valid/ready channel, and runs a watchdog.
module mem_req_ctrl #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_wr_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0]      req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic [ADDR_WIDTH-1:0] rsp_addr_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wr_data_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_rd_data_i,
  output logic                  busy_o,
  output logic                  timeout_err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state, state_next;
  logic                  fifo_wr   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [WIDTH-1:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [WD_W-1:0]       wd_cnt;
  logic                  push, pop, wd_expired, rsp_load, err_set;

  assign req_ready_o = (count != CNT_W'(FIFO_DEPTH));
  assign push        = req_valid_i && req_ready_o;
  assign busy_o      = (state != IDLE) || (count != '0);
  assign wd_expired  = (wd_cnt == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    rsp_load   = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (mem_ready_i) begin
          if (!mem_wr_rd_o) begin
            rsp_load   = 1'b1;
            state_next = RESP;
          end else begin
            state_next = IDLE;
          end
        end else if (wd_expired) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FIFO storage carries no reset; occupancy is governed by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr[wr_ptr]   <= req_wr_i;
      fifo_addr[wr_ptr] <= req_addr_i;
      fifo_data[wr_ptr] <= req_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      wd_cnt        <= '0;
      mem_valid_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      timeout_err_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // The issue pulse lasts exactly the single ISSUE cycle that follows a pop.
      mem_valid_o <= pop;
      if (state == ISSUE)
        wd_cnt <= '0;
      else if (state == WAIT && !mem_ready_i && !wd_expired)
        wd_cnt <= wd_cnt + WD_W'(1);
      if (err_set) timeout_err_o <= 1'b1;
      if (rsp_load)
        rsp_valid_o <= 1'b1;
      else if (state == RESP && rsp_ready_i)
        rsp_valid_o <= 1'b0;
    end
  end

  // Memory-side fields stay stable from one pop to the next; response fields from capture to capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wr_rd_o   <= 1'b0;
      mem_addr_o    <= '0;
      mem_wr_data_o <= '0;
      rsp_data_o    <= '0;
      rsp_addr_o    <= '0;
    end else begin
      if (pop) begin
        mem_wr_rd_o   <= fifo_wr[rd_ptr];
        mem_addr_o    <= fifo_addr[rd_ptr];
        mem_wr_data_o <= fifo_data[rd_ptr];
      end
      if (rsp_load) begin
        rsp_data_o <= mem_rd_data_i;
        rsp_addr_o <= mem_addr_o;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl with a behavioural handshake memory on the memory side.
module tb_mem_req_ctrl;
  localparam int WIDTH = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int FD    = 4;
  localparam int TO    = 16;

  logic clk = 1'b0;
  logic rst;
  logic req_valid_i, req_ready_o, req_wr_i;
  logic [AW-1:0] req_addr_i;
  logic [WIDTH-1:0] req_wdata_i;
  logic rsp_valid_o, rsp_ready_i;
  logic [WIDTH-1:0] rsp_data_o;
  logic [AW-1:0] rsp_addr_o;
  logic mem_valid_o, mem_wr_rd_o;
  logic [AW-1:0] mem_addr_o;
  logic [WIDTH-1:0] mem_wr_data_o;
  logic mem_ready_i;
  logic [WIDTH-1:0] mem_rd_data_i;
  logic busy_o, timeout_err_o;
  logic [2*WIDTH+2*AW+3:0] all_outs;

  typedef struct packed {logic [AW-1:0] addr; logic [WIDTH-1:0] data;} rsp_t;
  typedef struct packed {logic wr; logic [AW-1:0] addr;} iss_t;

  rsp_t exp_q[$];
  rsp_t obs_q[$];
  iss_t iss_q[$];
  iss_t iss_exp[$];
  int obs_idx = 0;
  int mv_cycles = 0;
  int rv_cycles = 0;
  logic [WIDTH-1:0] shadow  [DEPTH];
  logic [WIDTH-1:0] mem_arr [DEPTH];
  int n_cmp = 0;
  int n_bad = 0;
  int mem_lat = 0;
  bit mem_dead = 1'b0;
  int late_req = 0;
  int late_done = 0;

  always #5 clk = ~clk;

  assign all_outs = {mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wr_data_o,
                     rsp_valid_o, rsp_data_o, rsp_addr_o, timeout_err_o};

  mem_req_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_addr_o(rsp_addr_o),
    .mem_valid_o(mem_valid_o), .mem_wr_rd_o(mem_wr_rd_o), .mem_addr_o(mem_addr_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_ready_i(mem_ready_i), .mem_rd_data_i(mem_rd_data_i),
    .busy_o(busy_o), .timeout_err_o(timeout_err_o)
  );

  // Memory model: ready arrives the cycle after the issue pulse plus mem_lat extra cycles.
  initial begin : responder
    logic cw;
    logic [AW-1:0] ca;
    logic [WIDTH-1:0] cd;
    mem_ready_i = 1'b0;
    mem_rd_data_i = '0;
    for (int i = 0; i < DEPTH; i++) mem_arr[i] = 16'hA000 + 16'(i);
    forever begin
      @(posedge clk); #1;
      if (late_req != late_done) begin
        mem_ready_i = 1'b1;
        @(posedge clk); #1;
        mem_ready_i = 1'b0;
        late_done++;
      end else if (mem_valid_o === 1'b1 && !mem_dead && rst === 1'b0) begin
        cw = mem_wr_rd_o; ca = mem_addr_o; cd = mem_wr_data_o;
        @(posedge clk); #1;
        repeat (mem_lat) begin @(posedge clk); #1; end
        if (cw) mem_arr[ca] = cd;
        mem_rd_data_i = cw ? '0 : mem_arr[ca];
        mem_ready_i = 1'b1;
        @(posedge clk); #1;
        mem_ready_i = 1'b0;
      end
    end
  end

  // Output monitor: records issues and accepted responses for the tests to consume.
  initial begin : monitor
    iss_t it;
    rsp_t rt;
    forever begin
      @(negedge clk);
      if (mem_valid_o === 1'b1) begin
        mv_cycles++;
        it.wr = mem_wr_rd_o; it.addr = mem_addr_o;
        iss_q.push_back(it);
      end
      if (rsp_valid_o === 1'b1) rv_cycles++;
      if (rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1) begin
        rt.addr = rsp_addr_o; rt.data = rsp_data_o;
        obs_q.push_back(rt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic push_req(input logic wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                          output int waited);
    bit acc;
    iss_t it;
    rsp_t rt;
    req_valid_i = 1'b1; req_wr_i = wr; req_addr_i = a; req_wdata_i = d;
    waited = 0; acc = 1'b0;
    for (int g = 0; g < 200 && !acc; g++) begin
      @(negedge clk);
      acc = (req_ready_o === 1'b1);
      @(posedge clk); #1;
      if (!acc) waited++;
    end
    req_valid_i = 1'b0;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL push_accept: req_ready_o=%b, required 1 within 200 cycles", req_ready_o);
    end else begin
      it.wr = wr; it.addr = a;
      iss_exp.push_back(it);
      if (wr) shadow[a] = d;
      else begin
        rt.addr = a; rt.data = shadow[a];
        exp_q.push_back(rt);
      end
    end
  endtask

  task automatic drain_one(output rsp_t got, output bit ok);
    ok = 1'b0; got = '0;
    for (int g = 0; g < 400 && !ok; g++) begin
      if (obs_q.size() > obs_idx) begin
        got = obs_q[obs_idx]; obs_idx++; ok = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (all_outs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h, required 0", all_outs); end
    n_cmp++;
    if (req_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b, required 1", req_ready_o); end
    n_cmp++;
    if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int w, mv0, rv0;
    rsp_t got, e;
    bit ok;
    logic [3:0] seen;
    rsp_ready_i = 1'b1;
    mv0 = mv_cycles; rv0 = rv_cycles;
    push_req(1'b1, 6'd5, 16'hBEEF, w);
    push_req(1'b0, 6'd5, '0, w);
    drain_one(got, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || got !== e) begin
      n_bad++; $display("FAIL wr_rd_resp: got addr=%0d data=%h, required addr=%0d data=%h", got.addr, got.data, e.addr, e.data);
    end
    repeat (4) @(posedge clk); #1;
    n_cmp++;
    if (mv_cycles - mv0 != 2) begin n_bad++; $display("FAIL wr_rd_pulses: got %0d, required 2", mv_cycles - mv0); end
    n_cmp++;
    if (rv_cycles - rv0 != 1) begin n_bad++; $display("FAIL wr_rd_rsp_cycles: got %0d, required 1", rv_cycles - rv0); end
    // Latency of a single read from an empty FIFO.
    push_req(1'b0, 6'd20, '0, w);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen[k] = (k == 3) ? rsp_valid_o : mem_valid_o;
    end
    n_cmp++;
    if (seen !== 4'b1010) begin n_bad++; $display("FAIL read_latency: got %b, required 1010", seen); end
    drain_one(got, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || got !== e) begin
      n_bad++; $display("FAIL latency_resp: got addr=%0d data=%h, required addr=%0d data=%h", got.addr, got.data, e.addr, e.data);
    end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_fifo_full();
    int tw [6] = '{1, 0, 1, 0, 0, 1};
    int ta [6] = '{10, 10, 11, 11, 10, 12};
    int td [6] = '{16'h1111, 0, 16'h2222, 0, 0, 16'h3333};
    int waited [6];
    int eb, ob, first_sum, gd;
    rsp_t got, e;
    bit ok;
    mem_lat = 10; rsp_ready_i = 1'b1;
    eb = iss_exp.size(); ob = iss_q.size();
    for (int i = 0; i < 6; i++) push_req(tw[i][0], AW'(ta[i]), WIDTH'(td[i]), waited[i]);
    first_sum = 0;
    for (int i = 0; i < 5; i++) first_sum += waited[i];
    n_cmp++;
    if (first_sum != 0) begin n_bad++; $display("FAIL fifo_first_five_stall: got %0d, required 0", first_sum); end
    n_cmp++;
    if (waited[5] == 0) begin n_bad++; $display("FAIL fifo_full_stall: got %0d, required >0", waited[5]); end
    for (int i = 0; i < 3; i++) begin
      drain_one(got, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || got !== e) begin
        n_bad++; $display("FAIL fifo_resp_%0d: got addr=%0d data=%h, required addr=%0d data=%h", i, got.addr, got.data, e.addr, e.data);
      end
    end
    gd = 0;
    while (busy_o !== 1'b0 && gd < 300) begin @(posedge clk); #1; gd++; end
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (iss_q.size() - ob != 6) begin
      n_bad++; $display("FAIL fifo_issue_count: got %0d, required 6", iss_q.size() - ob);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (iss_q[ob+i] !== iss_exp[eb+i]) begin
          n_bad++; $display("FAIL fifo_order_%0d: got %h, required %h", i, iss_q[ob+i], iss_exp[eb+i]);
        end
      end
    end
    mem_lat = 0;
  endtask

  task automatic test_rsp_backpressure();
    int w, mv0, bad, gd;
    logic [WIDTH-1:0] d0;
    logic [AW-1:0] a0;
    rsp_t got, e;
    bit ok;
    rsp_ready_i = 1'b0;
    push_req(1'b0, 6'd3, '0, w);
    push_req(1'b1, 6'd7, 16'h7777, w);
    gd = 0;
    do begin @(negedge clk); gd++; end while (rsp_valid_o !== 1'b1 && gd < 50);
    d0 = rsp_data_o; a0 = rsp_addr_o; mv0 = mv_cycles; bad = 0;
    e = exp_q[0];
    n_cmp++;
    if (d0 !== e.data || a0 !== e.addr) begin
      n_bad++; $display("FAIL bp_data: got addr=%0d data=%h, required addr=%0d data=%h", a0, d0, e.addr, e.data);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== d0 || rsp_addr_o !== a0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable cycles, required 0", bad); end
    n_cmp++;
    if (mv_cycles != mv0) begin n_bad++; $display("FAIL bp_no_issue: got %0d pulses, required 0", mv_cycles - mv0); end
    @(posedge clk); #1 rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid_o, mem_valid_o} !== 2'b00) begin
      n_bad++; $display("FAIL bp_exit: got rsp_valid/mem_valid=%b, required 00", {rsp_valid_o, mem_valid_o});
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_valid_o, mem_wr_rd_o, mem_addr_o} !== {2'b11, 6'd7}) begin
      n_bad++; $display("FAIL bp_next_issue: got %b/%b/%0d, required 1/1/7", mem_valid_o, mem_wr_rd_o, mem_addr_o);
    end
    drain_one(got, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || got !== e) begin
      n_bad++; $display("FAIL bp_resp: got addr=%0d data=%h, required addr=%0d data=%h", got.addr, got.data, e.addr, e.data);
    end
    repeat (6) @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int w, o0, gd;
    logic err_pre, err_post;
    rsp_t got, e;
    bit ok;
    mem_dead = 1'b1; rsp_ready_i = 1'b1; o0 = obs_q.size();
    err_pre = 1'bx; err_post = 1'bx;
    push_req(1'b0, 6'd9, '0, w);
    gd = 0;
    do begin @(negedge clk); gd++; end while (mem_valid_o !== 1'b1 && gd < 10);
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      if (k == TO) err_pre = timeout_err_o;
      if (k == TO + 1) err_post = timeout_err_o;
    end
    n_cmp++;
    if (err_pre !== 1'b0) begin n_bad++; $display("FAIL timeout_early: got %b, required 0", err_pre); end
    n_cmp++;
    if (err_post !== 1'b1) begin n_bad++; $display("FAIL timeout_flag: got %b, required 1", err_post); end
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    mem_dead = 1'b0;
    n_cmp++;
    if (obs_q.size() != o0) begin n_bad++; $display("FAIL timeout_no_resp: got %0d responses, required 0", obs_q.size() - o0); end
    push_req(1'b0, 6'd3, '0, w);
    drain_one(got, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || got !== e) begin
      n_bad++; $display("FAIL timeout_recover: got addr=%0d data=%h, required addr=%0d data=%h", got.addr, got.data, e.addr, e.data);
    end
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (timeout_err_o !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got %b, required 1", timeout_err_o); end
  endtask

  task automatic test_reset_midop();
    int w, o0, mv0;
    mem_dead = 1'b1; rsp_ready_i = 1'b1; o0 = obs_q.size();
    push_req(1'b0, 6'd1, '0, w);
    push_req(1'b0, 6'd2, '0, w);
    push_req(1'b0, 6'd4, '0, w);
    push_req(1'b0, 6'd6, '0, w);
    @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b1) begin n_bad++; $display("FAIL midop_busy: got %b, required 1", busy_o); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (all_outs !== '0) begin n_bad++; $display("FAIL midop_outputs: got %h, required 0", all_outs); end
    n_cmp++;
    if ({busy_o, req_ready_o} !== 2'b01) begin
      n_bad++; $display("FAIL midop_busy_ready: got %b, required 01", {busy_o, req_ready_o});
    end
    exp_q.delete();
    mem_dead = 1'b0; mv0 = mv_cycles;
    @(posedge clk); #1 late_req++;
    repeat (6) @(posedge clk); #1;
    n_cmp++;
    if (obs_q.size() != o0 || rsp_valid_o !== 1'b0 || mv_cycles != mv0) begin
      n_bad++; $display("FAIL midop_late_ready: got %0d responses rsp_valid=%b pulses=%0d, required 0/0/0",
                        obs_q.size() - o0, rsp_valid_o, mv_cycles - mv0);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid_i = 1'b0; req_wr_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = 16'hA000 + 16'(i);
    test_reset();
    test_write_read();
    test_fifo_full();
    test_rsp_backpressure();
    test_timeout();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
